// File: rtl/midi_voice_allocator_if.sv
// midi_voice_allocator_if: note-event handshake between the MIDI parser and the voice allocator
interface midi_voice_allocator_if #(
    parameter int NOTE_BITS = 7
) ();
    logic                 ev_valid;
    logic                 ev_ready;
    logic                 ev_note_on;
    logic [NOTE_BITS-1:0] ev_note;

    modport master (output ev_valid, output ev_note_on, output ev_note, input ev_ready);
    modport slave  (input ev_valid, input ev_note_on, input ev_note, output ev_ready);
endinterface

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: assigns note events to voices by same-note reuse, lowest free voice, then LRU steal
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    midi_voice_allocator_if.slave           ev,
    input  logic                            all_notes_off_i,
    output logic [NUM_VOICES-1:0]           voice_gate_o,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note_o,
    output logic [NUM_VOICES-1:0]           voice_trig_o,
    output logic                            busy_o
);
    localparam int IW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SEARCH, APPLY} state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 on_q, on_d;
    logic [NOTE_BITS-1:0] note_q, note_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 match_ok_q, match_ok_d;
    logic [IW-1:0]        match_q, match_d;
    logic                 free_ok_q, free_ok_d;
    logic [IW-1:0]        free_q, free_d;
    logic [IW-1:0]        oldest_q, oldest_d;
    logic [IW-1:0]        tgt;
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic [NOTE_BITS-1:0] vnote_q [NUM_VOICES];
    logic [NOTE_BITS-1:0] vnote_d [NUM_VOICES];
    logic [IW-1:0]        age_q [NUM_VOICES];
    logic [IW-1:0]        age_d [NUM_VOICES];

    assign tgt          = match_ok_q ? match_q : free_ok_q ? free_q : oldest_q;
    assign ev.ev_ready  = ready_q;
    assign voice_gate_o = gate_q;
    assign voice_trig_o = trig_q;
    assign busy_o       = state_q != IDLE;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_flat
        assign voice_note_o[v*NOTE_BITS +: NOTE_BITS] = vnote_q[v];
    end

    // Next-state: accept in IDLE, scan one voice per SEARCH cycle, commit in APPLY; panic overrides all
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        on_d       = on_q;
        note_d     = note_q;
        idx_d      = idx_q;
        match_ok_d = match_ok_q;
        match_d    = match_q;
        free_ok_d  = free_ok_q;
        free_d     = free_q;
        oldest_d   = oldest_q;
        gate_d     = gate_q;
        trig_d     = '0;
        vnote_d    = vnote_q;
        age_d      = age_q;
        case (state_q)
            IDLE: begin
                if (!ready_q) begin
                    ready_d = 1'b1;
                end else if (ev.ev_valid) begin
                    ready_d    = 1'b0;
                    state_d    = SEARCH;
                    on_d       = ev.ev_note_on;
                    note_d     = ev.ev_note;
                    idx_d      = '0;
                    match_ok_d = 1'b0;
                    free_ok_d  = 1'b0;
                    oldest_d   = '0;
                end
            end
            SEARCH: begin
                if (!match_ok_q && gate_q[idx_q] && vnote_q[idx_q] == note_q) begin
                    match_ok_d = 1'b1;
                    match_d    = idx_q;
                end
                if (!free_ok_q && !gate_q[idx_q]) begin
                    free_ok_d = 1'b1;
                    free_d    = idx_q;
                end
                if (age_q[idx_q] == IW'(NUM_VOICES - 1))
                    oldest_d = idx_q;
                idx_d   = idx_q + IW'(1);
                state_d = idx_q == IW'(NUM_VOICES - 1) ? APPLY : SEARCH;
            end
            APPLY: begin
                state_d = IDLE;
                if (on_q) begin
                    gate_d[tgt]  = 1'b1;
                    vnote_d[tgt] = note_q;
                    trig_d[tgt]  = 1'b1;
                    for (int i = 0; i < NUM_VOICES; i++)
                        age_d[i] = IW'(i) == tgt ? '0 :
                                   age_q[i] < age_q[tgt] ? age_q[i] + IW'(1) : age_q[i];
                end else begin
                    for (int i = 0; i < NUM_VOICES; i++)
                        if (gate_q[i] && vnote_q[i] == note_q)
                            gate_d[i] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (all_notes_off_i) begin
            gate_d  = '0;
            trig_d  = '0;
            state_d = IDLE;
            ready_d = 1'b1;
        end
    end

    // State and voice registers; ages restart as the identity permutation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            on_q       <= 1'b0;
            note_q     <= '0;
            idx_q      <= '0;
            match_ok_q <= 1'b0;
            match_q    <= '0;
            free_ok_q  <= 1'b0;
            free_q     <= '0;
            oldest_q   <= '0;
            gate_q     <= '0;
            trig_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vnote_q[i] <= '0;
                age_q[i]   <= IW'(i);
            end
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            on_q       <= on_d;
            note_q     <= note_d;
            idx_q      <= idx_d;
            match_ok_q <= match_ok_d;
            match_q    <= match_d;
            free_ok_q  <= free_ok_d;
            free_q     <= free_d;
            oldest_q   <= oldest_d;
            gate_q     <= gate_d;
            trig_q     <= trig_d;
            vnote_q    <= vnote_d;
            age_q      <= age_d;
        end
    end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed and random note events checked against an LRU-queue voice model
`timescale 1ns/1ps
module tb_midi_voice_allocator;
    localparam int N  = 4;
    localparam int NB = 7;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            ano   = 1'b0;
    logic [N-1:0]    gate;
    logic [N-1:0]    trig;
    logic [N*NB-1:0] vnote;
    logic            busy;

    midi_voice_allocator_if #(.NOTE_BITS(NB)) ev ();

    midi_voice_allocator #(.NUM_VOICES(N), .NOTE_BITS(NB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ev             (ev),
        .all_notes_off_i(ano),
        .voice_gate_o   (gate),
        .voice_note_o   (vnote),
        .voice_trig_o   (trig),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    bit m_gate [N];
    int m_note [N];
    int lru [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] mg();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_gate[i];
        return r;
    endfunction

    function automatic logic [N*NB-1:0] mn();
        logic [N*NB-1:0] r;
        for (int i = 0; i < N; i++) r[i*NB +: NB] = NB'(m_note[i]);
        return r;
    endfunction

    task automatic model_reset();
        lru = {};
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 1'b0;
            m_note[i] = 0;
        end
        for (int i = N - 1; i >= 0; i--) lru.push_back(i);
    endtask

    task automatic model_panic();
        for (int i = 0; i < N; i++) m_gate[i] = 1'b0;
    endtask

    task automatic model_event(input bit on, input int note, output logic [N-1:0] t);
        int tg = -1;
        t = '0;
        if (on) begin
            for (int i = 0; i < N; i++) if (tg < 0 && m_gate[i] && m_note[i] == note) tg = i;
            for (int i = 0; i < N; i++) if (tg < 0 && !m_gate[i]) tg = i;
            if (tg < 0) tg = lru[0];
            m_gate[tg] = 1'b1;
            m_note[tg] = note;
            t[tg]      = 1'b1;
            for (int k = 0; k < lru.size(); k++)
                if (lru[k] == tg) begin
                    lru.delete(k);
                    break;
                end
            lru.push_back(tg);
        end else begin
            for (int i = 0; i < N; i++) if (m_gate[i] && m_note[i] == note) m_gate[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (ev.ev_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("ready_wait", 64'(ev.ev_ready), 64'(1));
    endtask

    task automatic do_event(input bit on, input int note, input string tag);
        logic [N-1:0] t;
        wait_ready();
        ev.ev_valid   = 1'b1;
        ev.ev_note_on = on;
        ev.ev_note    = NB'(note);
        tick();
        ev.ev_valid   = 1'($urandom);
        ev.ev_note_on = 1'($urandom);
        ev.ev_note    = NB'($urandom);
        chk({tag, ":ready_drop"}, 64'(ev.ev_ready), 64'(0));
        chk({tag, ":busy"}, 64'(busy), 64'(1));
        repeat (N) tick();
        chk({tag, ":gate_hold"}, 64'(gate), 64'(mg()));
        chk({tag, ":trig_early"}, 64'(trig), 64'(0));
        model_event(on, note, t);
        tick();
        chk({tag, ":gate"}, 64'(gate), 64'(mg()));
        chk({tag, ":note"}, 64'(vnote), 64'(mn()));
        chk({tag, ":trig"}, 64'(trig), 64'(t));
        chk({tag, ":ready_apply"}, 64'(ev.ev_ready), 64'(0));
        tick();
        ev.ev_valid = 1'b0;
        chk({tag, ":trig_end"}, 64'(trig), 64'(0));
        chk({tag, ":ready_back"}, 64'(ev.ev_ready), 64'(1));
        chk({tag, ":idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        ev.ev_valid   = 1'b0;
        ev.ev_note_on = 1'b0;
        ev.ev_note    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_gate", 64'(gate), 64'(0));
        chk("rst_note", 64'(vnote), 64'(0));
        chk("rst_trig", 64'(trig), 64'(0));
        chk("rst_ready", 64'(ev.ev_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(ev.ev_ready), 64'(0));
        tick();
        chk("ready_after_release", 64'(ev.ev_ready), 64'(1));

        do_event(1'b1, 60, "on60");
        chk("on60_v0", 64'(vnote[6:0]), 64'(60));
        do_event(1'b1, 62, "on62");
        do_event(1'b1, 64, "on64");
        do_event(1'b1, 67, "on67");
        do_event(1'b1, 69, "steal69");
        chk("steal69_gate", 64'(gate), 64'(4'b1111));
        chk("steal69_v0", 64'(vnote[6:0]), 64'(69));

        ano = 1'b1;
        tick();
        ano = 1'b0;
        model_panic();
        chk("panic_gate", 64'(gate), 64'(0));
        do_event(1'b1, 60, "re60");
        do_event(1'b1, 62, "re62");
        do_event(1'b1, 64, "re64");
        do_event(1'b0, 62, "off62");
        chk("off62_gate", 64'(gate), 64'(4'b0101));
        chk("off62_v1", 64'(vnote[13:7]), 64'(62));
        do_event(1'b1, 72, "on72");
        chk("on72_v1", 64'(vnote[13:7]), 64'(72));
        do_event(1'b1, 64, "retrig64");
        do_event(1'b1, 80, "on80");
        do_event(1'b1, 81, "steal81");
        do_event(1'b0, 50, "off50");

        wait_ready();
        ev.ev_valid   = 1'b1;
        ev.ev_note_on = 1'b1;
        ev.ev_note    = NB'(60);
        tick();
        ev.ev_valid = 1'b0;
        tick();
        ano = 1'b1;
        tick();
        ano = 1'b0;
        model_panic();
        chk("abort_gate", 64'(gate), 64'(0));
        chk("abort_trig", 64'(trig), 64'(0));
        chk("abort_ready", 64'(ev.ev_ready), 64'(1));
        chk("abort_idle", 64'(busy), 64'(0));
        for (int c = 0; c < N + 2; c++) begin
            tick();
            chk("abort_no_trig", 64'(trig), 64'(0));
        end

        do_event(1'b1, 65, "pre_race");
        ev.ev_valid   = 1'b1;
        ev.ev_note_on = 1'b1;
        ev.ev_note    = NB'(70);
        ano           = 1'b1;
        tick();
        ano         = 1'b0;
        ev.ev_valid = 1'b0;
        model_panic();
        chk("race_not_taken", 64'(busy), 64'(0));
        chk("race_ready", 64'(ev.ev_ready), 64'(1));
        chk("race_gate", 64'(gate), 64'(0));
        repeat (N + 2) tick();
        chk("race_no_trig", 64'(trig), 64'(0));

        for (int r = 0; r < 120; r++) begin
            if ($urandom_range(0, 15) == 0) begin
                ano = 1'b1;
                tick();
                ano = 1'b0;
                model_panic();
                chk("rand_panic", 64'(gate), 64'(mg()));
            end
            do_event($urandom_range(0, 3) != 0, 60 + int'($urandom_range(0, 7)), "rand");
        end

        wait_ready();
        ev.ev_valid   = 1'b1;
        ev.ev_note_on = 1'b1;
        ev.ev_note    = NB'(90);
        tick();
        ev.ev_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_gate", 64'(gate), 64'(0));
        chk("mid_rst_note", 64'(vnote), 64'(0));
        chk("mid_rst_trig", 64'(trig), 64'(0));
        chk("mid_rst_ready", 64'(ev.ev_ready), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(ev.ev_ready), 64'(1));
        do_event(1'b1, 61, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
